mem_arbiter_fsm: RTL and testbench

- Registered, grant-locking arbiter that shares the single RAM port between three requesters: instruction fetch port 0, instruction fetch port 1, and the data port driven by bus_control.
- Replaces purely combinational priority selection with an FSM that holds a grant until the RAM completes.
- Data normally wins. Instruction ports alternate round-robin. A per-port starvation counter forces an instruction grant after MAX_WAIT losing arbitrations.

---
 rtl/mem_arbiter_fsm.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_fsm.sv
// Grant-locking arbiter sharing one RAM port between two instruction fetch
// ports and the data port. Data normally wins and instruction ports alternate
// round-robin. A per-port starvation counter promotes an instruction port above
// data once it has lost MAX_WAIT arbitrations in a row.

// Per-port saturating count of arbitrations lost to the data port.
module mem_arbiter_starve #(
  parameter int CW       = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Clearing takes priority over counting; the count saturates at MAX_WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                                    cnt_d = '0;
    else if (inc_i && (cnt_q != CW'(MAX_WAIT)))   cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module mem_arbiter_fsm #(
  parameter int MAX_WAIT = 4,
  parameter int CW       = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic [31:0]      daddr,
  input  logic [31:0]      dstore,
  output logic             dwait,
  output logic [31:0]      dload,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);
  localparam int         NP         = 2;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I0, SERVE_I1} state_t;

  state_t state_q, state_d;
  logic   rr_q, rr_d;
  logic   d_req;
  logic   own;
  logic   ram_done;

  logic [NP-1:0]         clr, inc, starve;
  logic [NP-1:0][CW-1:0] cnt_w;

  assign d_req    = dREN | dWEN;
  assign own      = (state_q == SERVE_I1);
  assign ram_done = (ramstate == RAM_ACCESS);

  genvar g;
  for (g = 0; g < NP; g++) begin : g_port
    mem_arbiter_starve #(.CW(CW), .MAX_WAIT(MAX_WAIT)) u_starve (
      .CLK   (CLK),
      .nRST  (nRST),
      .clr_i (clr[g]),
      .inc_i (inc[g]),
      .cnt_o (cnt_w[g])
    );
    // A starving port only counts while it is still asking for the RAM.
    assign starve[g] = iREN[g] && (cnt_w[g] == CW'(MAX_WAIT));
  end

  function automatic state_t i_state(input logic p);
    return p ? SERVE_I1 : SERVE_I0;
  endfunction

  // Arbitration in IDLE, grant hold/release in the serve states, counter control.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    clr     = '0;
    inc     = '0;
    case (state_q)
      IDLE: begin
        if (starve[rr_q])       state_d = i_state(rr_q);
        else if (starve[~rr_q]) state_d = i_state(~rr_q);
        else if (d_req)         state_d = SERVE_D;
        else if (iREN[rr_q])    state_d = i_state(rr_q);
        else if (iREN[~rr_q])   state_d = i_state(~rr_q);
        // An idle port forgets its history; a requesting port that loses to
        // data moves one step closer to promotion.
        clr = ~iREN;
        if (d_req && (starve == '0)) inc = iREN;
      end
      SERVE_D: begin
        if (!d_req || ram_done) state_d = IDLE;
      end
      SERVE_I0, SERVE_I1: begin
        if (!iREN[own]) begin
          state_d = IDLE;
        end else if (ram_done) begin
          state_d  = IDLE;
          rr_d     = ~own;
          clr[own] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // RAM and requester outputs decoded from the grant; enables follow the
  // owner's request combinationally so a dropped request frees the RAM at once.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    case (state_q)
      SERVE_D: begin
        ramaddr = daddr;
        dload   = ramload;
        dwait   = !ram_done;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
      end
      SERVE_I0, SERVE_I1: begin
        ramaddr    = iaddr[own];
        ramREN     = iREN[own];
        iload[own] = ramload;
        iwait[own] = !ram_done;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// Directed bench for mem_arbiter_fsm: reset, single fetch, round-robin,
// data write priority, starvation promotion, request drop, ERROR hold and
// asynchronous reset during a grant.
module tb_mem_arbiter_fsm;
  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [1:0][31:0] iload;
  logic             dREN, dWEN;
  logic [31:0]      daddr, dstore;
  logic             dwait;
  logic [31:0]      dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter_fsm #(.MAX_WAIT(4), .CW(3)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 2'b11; dREN = 1'b1; dWEN = 1'b1;
    iaddr[0] = 32'h11; iaddr[1] = 32'h22; daddr = 32'h33; dstore = 32'h44;
    ramload = 32'h99; ramstate = ACCESS;
    #3;
    checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait: got %b expected 11", iwait); end
    checks++; if (dwait !== 1'b1) begin errors++; $display("FAIL reset_dwait: got %b expected 1", dwait); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b expected 00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_ram: got %h/%h expected 0/0", ramaddr, ramstore); end
    checks++; if (iload !== 64'h0 || dload !== 32'h0) begin errors++; $display("FAIL reset_load: got %h/%h expected 0/0", iload, dload); end
    tick();
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en_edge: got %b expected 00", {ramREN, ramWEN}); end
    iREN = 2'b00; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    nRST = 1'b1;
  endtask

  task automatic test_single_i0();
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY; ramload = 32'h1234_5678;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL single_idle_ren: got %b expected 0", ramREN); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL single_n1: got ren=%b addr=%h expected 1/40", ramREN, ramaddr); end
    checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL single_busy_wait: got %b expected 11", iwait); end
    ramstate = ACCESS;
    #1;
    checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL single_done_wait: got %b expected 10", iwait); end
    checks++; if (iload[0] !== 32'h1234_5678) begin errors++; $display("FAIL single_iload: got %h expected 12345678", iload[0]); end
    tick();
    iREN = 2'b00;
    #1;
    checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL single_after: got wait=%b ren=%b expected 11/0", iwait, ramREN); end
    checks++; if (dut.rr_q !== 1'b1) begin errors++; $display("FAIL single_rr: got %b expected 1", dut.rr_q); end
    ramstate = FREE;
  endtask

  task automatic test_round_robin();
    iaddr[0] = 32'hA0; iaddr[1] = 32'hB0; iREN = 2'b11; ramstate = ACCESS;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rr_idle0: got %b expected 0", ramREN); end
    for (int k = 1; k <= 8; k++) begin
      logic        srv, p;
      logic [31:0] ea;
      logic [1:0]  ew;
      tick();
      if (k == 8) iREN = 2'b00;
      #1;
      srv = k[0];
      p   = (((k >> 1) & 1) == 0);
      ea  = srv ? (p ? 32'hB0 : 32'hA0) : 32'h0;
      ew  = srv ? (p ? 2'b01 : 2'b10) : 2'b11;
      checks++;
      if (ramREN !== srv || ramaddr !== ea || iwait !== ew) begin
        errors++;
        $display("FAIL rr_cycle%0d: got ren=%b addr=%h wait=%b expected %b/%h/%b", k, ramREN, ramaddr, iwait, srv, ea, ew);
      end
    end
    ramstate = FREE;
  endtask

  task automatic test_data_write();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = BUSY;
    #1;
    checks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL dw_idle: got wen=%b dwait=%b expected 0/1", ramWEN, dwait); end
    tick();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL dw_en: got wen=%b ren=%b expected 1/0", ramWEN, ramREN); end
    checks++; if (ramstore !== 32'hDEAD_BEEF || ramaddr !== 32'h100) begin errors++; $display("FAIL dw_bus: got %h@%h expected deadbeef@100", ramstore, ramaddr); end
    checks++; if (dwait !== 1'b1 || iwait !== 2'b11) begin errors++; $display("FAIL dw_wait: got d=%b i=%b expected 1/11", dwait, iwait); end
    ramstate = ACCESS; ramload = 32'hCAFE_0001;
    #1;
    checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE_0001) begin errors++; $display("FAIL dw_done: got dwait=%b dload=%h expected 0/cafe0001", dwait, dload); end
    tick();
    dREN = 1'b0; dWEN = 1'b0;
    #1;
    checks++; if (ramWEN !== 1'b0 || ramstore !== 32'h0 || dwait !== 1'b1) begin errors++; $display("FAIL dw_bubble: got wen=%b st=%h dwait=%b expected 0/0/1", ramWEN, ramstore, dwait); end
    checks++; if (dut.cnt_w[0] !== 3'd1) begin errors++; $display("FAIL dw_cnt0: got %0d expected 1", dut.cnt_w[0]); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 2'b10) begin errors++; $display("FAIL dw_i0: got ren=%b addr=%h wait=%b expected 1/40/10", ramREN, ramaddr, iwait); end
    tick();
    iREN = 2'b00; ramstate = FREE;
    #1;
    checks++; if (dut.cnt_w[0] !== 3'd0 || ramREN !== 1'b0) begin errors++; $display("FAIL dw_end: got cnt=%0d ren=%b expected 0/0", dut.cnt_w[0], ramREN); end
  endtask

  task automatic test_starvation();
    dREN = 1'b1; dWEN = 1'b0; daddr = 32'h200; iREN = 2'b10; iaddr[1] = 32'hB0; ramstate = ACCESS;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL st_idle0: got %b expected 0", ramREN); end
    for (int k = 1; k <= 10; k++) begin
      logic        er;
      logic [31:0] ea;
      logic [1:0]  ei;
      logic        ed;
      tick();
      if (k == 10) begin dREN = 1'b0; iREN = 2'b00; end
      #1;
      if (k == 9)      begin er = 1'b1; ea = 32'hB0;  ei = 2'b01; ed = 1'b1; end
      else if (k[0])   begin er = 1'b1; ea = 32'h200; ei = 2'b11; ed = 1'b0; end
      else             begin er = 1'b0; ea = 32'h0;   ei = 2'b11; ed = 1'b1; end
      checks++;
      if (ramREN !== er || ramaddr !== ea || iwait !== ei || dwait !== ed) begin
        errors++;
        $display("FAIL st_cycle%0d: got ren=%b addr=%h iw=%b dw=%b expected %b/%h/%b/%b", k, ramREN, ramaddr, iwait, dwait, er, ea, ei, ed);
      end
      if (!k[0]) begin
        checks++;
        if (dut.cnt_w[1] !== ((k == 10) ? 3'd0 : 3'(k / 2))) begin
          errors++;
          $display("FAIL st_cnt%0d: got %0d expected %0d", k, dut.cnt_w[1], (k == 10) ? 0 : k / 2);
        end
      end
    end
    ramstate = FREE;
  endtask

  task automatic test_drop();
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    #1;
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dwait !== 1'b1) begin errors++; $display("FAIL drop_serve: got ren=%b addr=%h dwait=%b expected 1/300/1", ramREN, ramaddr, dwait); end
    dREN = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL drop_same_cycle: got %b expected 0", ramREN); end
    tick();
    checks++; if (ramaddr !== 32'h0 || ramREN !== 1'b0) begin errors++; $display("FAIL drop_idle: got addr=%h ren=%b expected 0/0", ramaddr, ramREN); end
    checks++; if (dut.rr_q !== 1'b0) begin errors++; $display("FAIL drop_rr: got %b expected 0", dut.rr_q); end
    ramstate = FREE;
  endtask

  task automatic test_error_reset();
    iREN = 2'b01; iaddr[0] = 32'h40; ramstate = ERROR; ramload = 32'h55AA_55AA;
    #1;
    tick();
    checks++; if (ramREN !== 1'b1 || iwait !== 2'b11) begin errors++; $display("FAIL err_serve: got ren=%b wait=%b expected 1/11", ramREN, iwait); end
    checks++; if (iload[0] !== 32'h55AA_55AA) begin errors++; $display("FAIL err_iload: got %h expected 55aa55aa", iload[0]); end
    tick();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL err_hold: got ren=%b addr=%h expected 1/40", ramREN, ramaddr); end
    nRST = 1'b0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL areset_ram: got ren=%b wen=%b addr=%h expected 0/0/0", ramREN, ramWEN, ramaddr); end
    checks++; if (iwait !== 2'b11 || iload !== 64'h0) begin errors++; $display("FAIL areset_i: got wait=%b iload=%h expected 11/0", iwait, iload); end
    iREN = 2'b00; ramstate = FREE;
    nRST = 1'b1;
    tick();
    checks++; if (dut.state_q !== 2'd0 || dut.rr_q !== 1'b0) begin errors++; $display("FAIL areset_after: got st=%0d rr=%b expected 0/0", dut.state_q, dut.rr_q); end
  endtask

  initial begin
    test_reset();
    test_single_i0();
    test_round_robin();
    test_data_write();
    test_starvation();
    test_drop();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
